// File: rtl/gray_monitor.sv
// ============================================================================
// Module  : gray_monitor
// Brief   : Checks a Gray counter stream for legal single-step forward moves,
//           converts accepted codes to binary, counts wraps, latches faults.
//           Optional overflow cross-check: define GRAY_MON_OVF_CHECK_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module gray_monitor #(
    parameter int WIDTH = 3,
    parameter int LAP_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Gray,
    input  logic             Overflow,
    output logic [WIDTH-1:0] Binary,
    output logic [LAP_W-1:0] Laps,
    output logic             Step,
    output logic             Error,
    output logic [1:0]       ErrCode
);

    localparam logic [0:0] S_TRACK = 1'b0;
    localparam logic [0:0] S_FAULT = 1'b1;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_MULTI = 2'b01;
    localparam logic [1:0] CODE_BACK  = 2'b10;
    localparam logic [1:0] CODE_OVF   = 2'b11;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [LAP_W-1:0] laps_q, laps_d;
    logic             step_q, step_d;
    logic [1:0]       code_q, code_d;

    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_bn;
    logic [WIDTH-1:0] w_bp;
    logic [WIDTH-1:0] w_bp_inc;
    logic             w_one_hot;
    logic             w_multi;
    logic             w_fwd;
    logic             w_accept;
    logic             w_wrap;
    logic             w_ovf_fault;
    logic [1:0]       w_cause;

    assign w_diff    = Gray ^ prev_q;
    assign w_bn      = gray2bin(Gray);
    assign w_bp      = gray2bin(prev_q);
    assign w_bp_inc  = w_bp + 1'b1;
    assign w_one_hot = (w_diff != '0) && ((w_diff & (w_diff - 1'b1)) == '0);
    assign w_multi   = (w_diff != '0) && !w_one_hot;
    assign w_fwd     = (w_bn == w_bp_inc);
    assign w_accept  = w_one_hot && w_fwd;
    assign w_wrap    = w_accept && (w_bp == '1);

`ifdef GRAY_MON_OVF_CHECK_EN
    logic ovf_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= Overflow;
        end
    end

    // Upstream raises Overflow on the same edge it wraps to 0, so a rise is
    // only legal when it coincides with an accepted wrap step.
    assign w_ovf_fault = Overflow && !ovf_q && !w_wrap;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = Overflow;
    assign w_ovf_fault  = 1'b0;
`endif

    always_comb begin
        w_cause = CODE_NONE;
        if (w_multi) begin
            w_cause = CODE_MULTI;
        end else if (w_one_hot && !w_fwd) begin
            w_cause = CODE_BACK;
        end else if (w_ovf_fault) begin
            w_cause = CODE_OVF;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_TRACK;
            prev_q  <= '0;
            bin_q   <= '0;
            laps_q  <= '0;
            step_q  <= 1'b0;
            code_q  <= CODE_NONE;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            bin_q   <= bin_d;
            laps_q  <= laps_d;
            step_q  <= step_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        bin_d   = bin_q;
        laps_d  = laps_q;
        step_d  = 1'b0;
        code_d  = code_q;
        if (state_q == S_TRACK) begin
            if (w_cause != CODE_NONE) begin
                state_d = S_FAULT;
                code_d  = w_cause;
            end else if (w_accept) begin
                prev_d = Gray;
                bin_d  = w_bn;
                step_d = 1'b1;
                if (w_wrap && (laps_q != '1)) begin
                    laps_d = laps_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        Binary  = bin_q;
        Laps    = laps_q;
        Step    = step_q;
        Error   = (state_q == S_FAULT);
        ErrCode = code_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_gray_monitor.sv
// ============================================================================
// Module  : tb_gray_monitor
// Brief   : Randomised and directed bench for gray_monitor against a
//           code-table reference model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_gray_monitor;

    localparam int WIDTH = 3;
    localparam int NCODE = 1 << WIDTH;
`ifdef GRAY_MON_OVF_CHECK_EN
    localparam int OVF_EN = 1;
`else
    localparam int OVF_EN = 0;
`endif

    logic             Clk;
    logic             Reset;
    logic [WIDTH-1:0] Gray;
    logic             Overflow;

    logic [WIDTH-1:0] bin_a, bin_b;
    logic [7:0]       laps_a;
    logic [1:0]       laps_b;
    logic             step_a, step_b, err_a, err_b;
    logic [1:0]       code_a, code_b;

    gray_monitor #(.WIDTH(WIDTH), .LAP_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .Gray(Gray), .Overflow(Overflow),
        .Binary(bin_a), .Laps(laps_a), .Step(step_a), .Error(err_a), .ErrCode(code_a)
    );

    gray_monitor #(.WIDTH(WIDTH), .LAP_W(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Gray(Gray), .Overflow(Overflow),
        .Binary(bin_b), .Laps(laps_b), .Step(step_b), .Error(err_b), .ErrCode(code_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Gray code of k is k ^ (k >> 1); invert by table search.
    function automatic int g2b(input int g);
        for (int k = 0; k < NCODE; k++) begin
            if ((k ^ (k >> 1)) == g) return k;
        end
        return 0;
    endfunction

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    // Reference model: binary of last accepted code, unsaturated lap total.
    int m_prev_b = 0;
    int m_laps   = 0;
    int m_step   = 0;
    int m_err    = 0;
    int m_code   = 0;
    int m_ovf    = 0;
    int gb, nbits;
    bit fwd, wrap, rise;

    always @(posedge Clk) begin
        m_step = 0;
        if (Reset) begin
            m_prev_b = 0; m_laps = 0; m_err = 0; m_code = 0; m_ovf = 0;
        end else begin
            if (m_err == 0) begin
                gb    = g2b(int'(Gray));
                nbits = $countones(Gray ^ WIDTH'(b2g(m_prev_b)));
                fwd   = (gb == (m_prev_b + 1) % NCODE);
                wrap  = (nbits == 1) && fwd && (m_prev_b == NCODE - 1);
                rise  = (OVF_EN != 0) && Overflow && (m_ovf == 0);
                if (nbits > 1) begin
                    m_err = 1; m_code = 1;
                end else if (nbits == 1 && !fwd) begin
                    m_err = 1; m_code = 2;
                end else if (rise && !wrap) begin
                    m_err = 1; m_code = 3;
                end else if (nbits == 1) begin
                    m_prev_b = gb;
                    m_step   = 1;
                    if (wrap) m_laps++;
                end
            end
            m_ovf = int'(Overflow);
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            cmp("Binary",   int'(bin_a),  m_prev_b);
            cmp("Laps",     int'(laps_a), (m_laps > 255) ? 255 : m_laps);
            cmp("Step",     int'(step_a), m_step);
            cmp("Error",    int'(err_a),  m_err);
            cmp("ErrCode",  int'(code_a), m_code);
            cmp("LapsSat",  int'(laps_b), (m_laps > 3) ? 3 : m_laps);
            cmp("BinarySat", int'(bin_b), m_prev_b);
        end
    end

    task automatic apply(input bit rst, input int g, input bit ovf);
        Reset    = rst;
        Gray     = WIDTH'(g);
        Overflow = ovf;
        @(posedge Clk);
        @(negedge Clk);
        #1;
    endtask

    int steps;
    int cnt;
    bit ovf_drv;
    int r;
    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        Reset = 1'b1; Gray = '0; Overflow = 1'b0;
        apply(1, 0, 0);
        chk_en = 1'b1;
        cmp("rst_Binary", int'(bin_a), 0);
        cmp("rst_Laps", int'(laps_a), 0);
        cmp("rst_Error", int'(err_a), 0);
        cmp("rst_ErrCode", int'(code_a), 0);

        // Five full laps; Overflow rises with the first wrap and stays high.
        for (int lap = 0; lap < 5; lap++) begin
            steps = 0;
            for (int s = 1; s <= NCODE; s++) begin
                apply(0, b2g(s % NCODE), (lap > 0) || (s == NCODE));
                steps += int'(step_a);
                if (lap == 0) cmp("lap_Binary", int'(bin_a), s % NCODE);
            end
            cmp("lap_steps", steps, NCODE);
            cmp("lap_sat", int'(laps_b), sat_exp[lap]);
        end
        cmp("lap_total", int'(laps_a), 5);
        cmp("lap_err", int'(err_a), 0);

        // Stall on 011.
        apply(1, 0, 0);
        apply(0, 1, 0);
        apply(0, 3, 0);
        cmp("stall_first", int'(step_a), 1);
        steps = 0;
        for (int i = 0; i < 5; i++) begin
            apply(0, 3, 0);
            steps += int'(step_a);
            cmp("stall_Binary", int'(bin_a), 2);
        end
        cmp("stall_steps", steps, 0);

        // Multi-bit jump 001 -> 010, then legal codes are ignored.
        apply(1, 0, 0);
        apply(0, 1, 0);
        apply(0, 2, 0);
        cmp("multi_Error", int'(err_a), 1);
        cmp("multi_Code", int'(code_a), 1);
        cmp("multi_Binary", int'(bin_a), 1);
        apply(0, 3, 0);
        apply(0, 2, 0);
        cmp("multi_Step", int'(step_a), 0);
        cmp("multi_hold", int'(bin_a), 1);

        // Backward step 011 -> 001, then reset recovers.
        apply(1, 0, 0);
        apply(0, 1, 0);
        apply(0, 3, 0);
        apply(0, 1, 0);
        cmp("back_Code", int'(code_a), 2);
        apply(1, 0, 0);
        cmp("back_rst_Error", int'(err_a), 0);
        cmp("back_rst_Code", int'(code_a), 0);
        cmp("back_rst_Binary", int'(bin_a), 0);
        apply(0, 1, 0);
        cmp("back_resume", int'(bin_a), 1);

        // Overflow rising while Gray holds at 010.
        apply(1, 0, 0);
        apply(0, 1, 0);
        apply(0, 3, 0);
        apply(0, 2, 0);
        apply(0, 2, 1);
        cmp("ovf_Error", int'(err_a), OVF_EN);
        cmp("ovf_Code", int'(code_a), OVF_EN * 3);

        // Random walk: mostly legal steps and stalls, some junk and resets.
        apply(1, 0, 0);
        cnt = 0; ovf_drv = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                cnt = 0; ovf_drv = 1'b0;
                apply(1, 0, 0);
            end else begin
                if (r < 60) begin
                    cnt = (cnt + 1) % NCODE;
                    if (cnt == 0) ovf_drv = 1'b1;
                end else if (r >= 88) begin
                    cnt = $urandom_range(0, NCODE - 1);
                end
                if ($urandom_range(0, 99) < 2) ovf_drv = ~ovf_drv;
                apply(0, b2g(cnt), ovf_drv);
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
